// File: rtl/int_memory_pkg.sv
// Shared widths, operand bundle and sequencer states for the int_memory arbiter.
package int_memory_pkg;

    localparam int MEM_DEPTH = 6;
    localparam int MEM_ADR_W = 3;
    localparam int MEM_DAT_W = 4;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef struct packed {
        logic                 wr;
        logic [MEM_ADR_W-1:0] adr;
        logic [MEM_DAT_W-1:0] di;
    } memop_t;

endpackage

// File: rtl/int_memory_rr2.sv
// Two-way round-robin picker for eligible requesters.
// Latency: combinational, no state.
// Backpressure: none; the caller decides when the result is used.
module int_memory_rr2 (
    input  logic aReq,
    input  logic bReq,
    input  logic ptrB,
    output logic winA,
    output logic winB,
    output logic ptrBNxt
);

    always_comb begin
        winA    = 1'b0;
        winB    = 1'b0;
        ptrBNxt = ptrB;
        if (aReq && bReq) begin
            // Contention: pointer chooses, then favours the loser next time.
            winB    = ptrB;
            winA    = !ptrB;
            ptrBNxt = !ptrB;
        end else if (aReq) begin
            winA = 1'b1;
        end else if (bReq) begin
            winB = 1'b1;
        end
    end

endmodule

// File: rtl/int_memory_arbiter.sv
// Two-port arbiter/sequencer for int_memory with post-reset zero-fill.
// Latency: request sampled in n, memory enabled in n+1, GNT/DO in n+2.
// Backpressure: requesters hold REQ until GNT; requests during zero-fill wait.
module int_memory_arbiter
    import int_memory_pkg::*;
#(
    parameter int DEPTH          = MEM_DEPTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 A_REQ,
    input  logic                 A_WR,
    input  logic [MEM_ADR_W-1:0] A_ADR,
    input  logic [MEM_DAT_W-1:0] A_DI,
    output logic                 A_GNT,
    output logic                 A_ERR,
    output logic [MEM_DAT_W-1:0] A_DO,
    input  logic                 B_REQ,
    input  logic                 B_WR,
    input  logic [MEM_ADR_W-1:0] B_ADR,
    input  logic [MEM_DAT_W-1:0] B_DI,
    output logic                 B_GNT,
    output logic                 B_ERR,
    output logic [MEM_DAT_W-1:0] B_DO,
    output logic [MEM_ADR_W-1:0] M_ADR,
    output logic [MEM_DAT_W-1:0] M_DI,
    output logic                 M_EN,
    output logic                 M_WR,
    input  logic [MEM_DAT_W-1:0] M_DO,
    output logic                 BUSY
);

    typedef logic [MEM_ADR_W:0] cnt_t;
    localparam cnt_t DEPTH_W = cnt_t'(DEPTH);

    state_t               state, stateNxt;
    cnt_t                 clrCnt, clrCntNxt;
    logic                 ptrB, ptrBNxt, rrPtrNxt;
    logic                 selB, selBNxt;
    logic                 mEnNxt, mWrNxt;
    logic [MEM_ADR_W-1:0] mAdrNxt;
    logic [MEM_DAT_W-1:0] mDiNxt;
    logic                 aGntNxt, bGntNxt, aErrNxt, bErrNxt, busyNxt;
    logic [MEM_DAT_W-1:0] aDoNxt, bDoNxt, rdDat;
    logic                 eligA, eligB, winA, winB, adrOk;
    memop_t               opA, opB, opWin;

    assign opA   = '{wr: A_WR, adr: A_ADR, di: A_DI};
    assign opB   = '{wr: B_WR, adr: B_ADR, di: B_DI};
    // A port completing this cycle is still holding its old request.
    assign eligA = A_REQ && !A_GNT;
    assign eligB = B_REQ && !B_GNT;
    assign opWin = winB ? opB : opA;
    assign adrOk = ({1'b0, M_ADR} < DEPTH_W);
    assign rdDat = adrOk ? M_DO : '0;

    int_memory_rr2 u_rr2 (
        .aReq    (eligA),
        .bReq    (eligB),
        .ptrB    (ptrB),
        .winA    (winA),
        .winB    (winB),
        .ptrBNxt (rrPtrNxt)
    );

    always_comb begin
        stateNxt  = state;
        clrCntNxt = clrCnt;
        ptrBNxt   = ptrB;
        selBNxt   = selB;
        mEnNxt    = M_EN;
        mWrNxt    = M_WR;
        mAdrNxt   = M_ADR;
        mDiNxt    = M_DI;
        aGntNxt   = 1'b0;
        bGntNxt   = 1'b0;
        aErrNxt   = 1'b0;
        bErrNxt   = 1'b0;
        aDoNxt    = A_DO;
        bDoNxt    = B_DO;
        busyNxt   = BUSY;
        unique case (state)
            CLEAR: begin
                if (!CLEAR_ON_RESET || clrCnt == DEPTH_W) begin
                    stateNxt = IDLE;
                    mEnNxt   = 1'b0;
                    mWrNxt   = 1'b0;
                    busyNxt  = 1'b0;
                end else begin
                    mEnNxt    = 1'b1;
                    mWrNxt    = 1'b1;
                    mDiNxt    = '0;
                    mAdrNxt   = clrCnt[MEM_ADR_W-1:0];
                    clrCntNxt = clrCnt + cnt_t'(1);
                end
            end
            IDLE, DONE: begin
                stateNxt = IDLE;
                if (winA || winB) begin
                    stateNxt = ACCESS;
                    selBNxt  = winB;
                    ptrBNxt  = rrPtrNxt;
                    mAdrNxt  = opWin.adr;
                    mDiNxt   = opWin.di;
                    mWrNxt   = opWin.wr;
                    // Out-of-range accesses never touch the memory.
                    mEnNxt   = ({1'b0, opWin.adr} < DEPTH_W);
                end
            end
            ACCESS: begin
                stateNxt = DONE;
                mEnNxt   = 1'b0;
                if (selB) begin
                    bGntNxt = 1'b1;
                    bErrNxt = !adrOk;
                    if (!M_WR) bDoNxt = rdDat;
                end else begin
                    aGntNxt = 1'b1;
                    aErrNxt = !adrOk;
                    if (!M_WR) aDoNxt = rdDat;
                end
            end
            default: stateNxt = CLEAR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= CLEAR;
            clrCnt <= '0;
            ptrB   <= 1'b0;
            selB   <= 1'b0;
            M_EN   <= 1'b0;
            M_WR   <= 1'b0;
            M_ADR  <= '0;
            M_DI   <= '0;
            A_GNT  <= 1'b0;
            B_GNT  <= 1'b0;
            A_ERR  <= 1'b0;
            B_ERR  <= 1'b0;
            A_DO   <= '0;
            B_DO   <= '0;
            BUSY   <= 1'b1;
        end else begin
            state  <= stateNxt;
            clrCnt <= clrCntNxt;
            ptrB   <= ptrBNxt;
            selB   <= selBNxt;
            M_EN   <= mEnNxt;
            M_WR   <= mWrNxt;
            M_ADR  <= mAdrNxt;
            M_DI   <= mDiNxt;
            A_GNT  <= aGntNxt;
            B_GNT  <= bGntNxt;
            A_ERR  <= aErrNxt;
            B_ERR  <= bErrNxt;
            A_DO   <= aDoNxt;
            B_DO   <= bDoNxt;
            BUSY   <= busyNxt;
        end
    end

endmodule

// File: tb/tb_int_memory_arbiter.sv
// Directed bench for int_memory_arbiter with a transaction-level reference model.
module tb_int_memory_arbiter;
    import int_memory_pkg::*;

    localparam int DEPTH = 6;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       A_REQ = 1'b0, A_WR = 1'b0, B_REQ = 1'b0, B_WR = 1'b0;
    logic [2:0] A_ADR = '0, B_ADR = '0;
    logic [3:0] A_DI = '0, B_DI = '0;
    logic       A_GNT, A_ERR, B_GNT, B_ERR, M_EN, M_WR, BUSY;
    logic [3:0] A_DO, B_DO, M_DI, M_DO;
    logic [2:0] M_ADR;

    int nChecks = 0;
    int nPass   = 0;

    always #5 CLK = ~CLK;

    int_memory_arbiter dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_WR(A_WR), .A_ADR(A_ADR), .A_DI(A_DI),
        .A_GNT(A_GNT), .A_ERR(A_ERR), .A_DO(A_DO),
        .B_REQ(B_REQ), .B_WR(B_WR), .B_ADR(B_ADR), .B_DI(B_DI),
        .B_GNT(B_GNT), .B_ERR(B_ERR), .B_DO(B_DO),
        .M_ADR(M_ADR), .M_DI(M_DI), .M_EN(M_EN), .M_WR(M_WR),
        .M_DO(M_DO), .BUSY(BUSY)
    );

    // Stand-in for the int_memory instance; starts with non-zero garbage.
    logic [3:0] memArr [0:7] = '{default: 4'h9};
    int         wrCnt = 0;
    assign M_DO = memArr[M_ADR];
    always @(posedge CLK) begin
        if (M_EN && M_WR) begin
            memArr[M_ADR] <= M_DI;
            wrCnt         <= wrCnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: expected outputs for the cycle following each edge.
    logic [3:0] refMem [0:7];
    bit         armed = 1'b0;
    bit         mBusy, mInFlight, mPtrB, mPort;
    int         clrK;
    logic       mWr;
    logic [2:0] mAdr;
    logic [3:0] mDi;
    bit         eGntA, eGntB, eErrA, eErrB, eMEn, eMWr;
    logic [3:0] eDoA, eDoB, eMDi;
    logic [2:0] eMAdr;

    always @(posedge CLK) begin : model
        bit         wasA, wasB, eA, eB, pickB, ok;
        logic [3:0] val;
        if (RST) begin
            armed = 1'b1; clrK = 0; mBusy = 1'b1; mInFlight = 1'b0; mPtrB = 1'b0;
            eGntA = 1'b0; eGntB = 1'b0; eErrA = 1'b0; eErrB = 1'b0;
            eDoA = '0; eDoB = '0; eMEn = 1'b0;
            for (int i = 0; i < 8; i++) refMem[i] = '0;
        end else if (mBusy) begin
            if (clrK < DEPTH) begin
                eMEn = 1'b1; eMWr = 1'b1; eMDi = '0; eMAdr = 3'(clrK); clrK++;
            end else begin
                eMEn = 1'b0; mBusy = 1'b0;
            end
        end else if (mInFlight) begin
            ok   = int'(mAdr) < DEPTH;
            eMEn = 1'b0;
            if (!mWr) begin
                val = ok ? refMem[mAdr] : 4'h0;
                if (mPort) eDoB = val; else eDoA = val;
            end else if (ok) begin
                refMem[mAdr] = mDi;
            end
            if (mPort) begin eGntB = 1'b1; eErrB = !ok; end
            else       begin eGntA = 1'b1; eErrA = !ok; end
            mInFlight = 1'b0;
        end else begin
            wasA = eGntA; wasB = eGntB;
            eGntA = 1'b0; eGntB = 1'b0; eErrA = 1'b0; eErrB = 1'b0;
            eA = A_REQ && !wasA;
            eB = B_REQ && !wasB;
            if (eA || eB) begin
                if (eA && eB) begin pickB = mPtrB; mPtrB = !mPtrB; end
                else pickB = eB;
                mPort = pickB;
                mWr   = pickB ? B_WR  : A_WR;
                mAdr  = pickB ? B_ADR : A_ADR;
                mDi   = pickB ? B_DI  : A_DI;
                eMEn  = int'(mAdr) < DEPTH;
                eMWr  = mWr; eMAdr = mAdr; eMDi = mDi;
                mInFlight = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            chk("BUSY", BUSY, mBusy);
            chk("A_GNT", A_GNT, eGntA);
            chk("B_GNT", B_GNT, eGntB);
            chk("A_ERR", A_ERR, eErrA);
            chk("B_ERR", B_ERR, eErrB);
            chk("A_DO", A_DO, eDoA);
            chk("B_DO", B_DO, eDoB);
            chk("M_EN", M_EN, eMEn);
            if (eMEn) begin
                chk("M_ADR", M_ADR, eMAdr);
                chk("M_WR", M_WR, eMWr);
                chk("M_DI", M_DI, eMDi);
            end
            chk("gnt_exclusive", A_GNT & B_GNT, 0);
        end
    end

    task automatic access(input bit portB, input bit wr, input logic [2:0] adr, input logic [3:0] di,
                          output int lat, output logic err, output logic [3:0] dout,
                          output logic [3:0] other);
        @(negedge CLK);
        if (portB) begin B_WR = wr; B_ADR = adr; B_DI = di; B_REQ = 1'b1; end
        else       begin A_WR = wr; A_ADR = adr; A_DI = di; A_REQ = 1'b1; end
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!(portB ? B_GNT : A_GNT) && lat < 20);
        err   = portB ? B_ERR : A_ERR;
        dout  = portB ? B_DO  : A_DO;
        other = portB ? A_DO  : B_DO;
        A_REQ = 1'b0;
        B_REQ = 1'b0;
    endtask

    task automatic waitBusyLow(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (BUSY !== 1'b0 && n < 20);
    endtask

    int gT[$];
    bit gP[$];
    task automatic runBoth(input int cycles, input bit hold);
        gT.delete();
        gP.delete();
        for (int i = 1; i <= cycles; i++) begin
            @(negedge CLK);
            if (A_GNT) begin gT.push_back(i); gP.push_back(1'b0); if (!hold) A_REQ = 1'b0; end
            if (B_GNT) begin gT.push_back(i); gP.push_back(1'b1); if (!hold) B_REQ = 1'b0; end
        end
        A_REQ = 1'b0;
        B_REQ = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int         lat, wrBase;
        logic       err;
        logic [3:0] dout, other;
        int         expT[5] = '{9, 11, 13, 15, 17};
        bit         expP[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset and zero-fill
        repeat (2) @(negedge CLK);
        chk("rst_busy", BUSY, 1);
        chk("rst_men", M_EN, 0);
        chk("rst_ado", A_DO, 0);
        chk("rst_bdo", B_DO, 0);
        wrBase = wrCnt;
        RST = 1'b0;
        waitBusyLow(lat);
        chk("clr_busy_fall", lat, 7);
        chk("clr_writes", wrCnt - wrBase, 6);
        for (int a = 0; a < DEPTH; a++) begin
            access(bit'(a % 2), 1'b0, 3'(a), 4'h0, lat, err, dout, other);
            chk("clr_read_do", dout, 0);
            chk("clr_read_lat", lat, 2);
        end

        // Basic write/read and DO isolation
        access(1'b1, 1'b1, 3'd1, 4'h7, lat, err, dout, other);
        chk("b_wr_lat", lat, 2);
        chk("b_wr_err", err, 0);
        access(1'b1, 1'b0, 3'd1, 4'h0, lat, err, dout, other);
        chk("b_rd_do", dout, 4'h7);
        access(1'b0, 1'b1, 3'd3, 4'hA, lat, err, dout, other);
        chk("a_wr_lat", lat, 2);
        chk("a_wr_err", err, 0);
        access(1'b0, 1'b0, 3'd3, 4'h0, lat, err, dout, other);
        chk("a_rd_do", dout, 4'hA);
        chk("a_rd_lat", lat, 2);
        chk("b_do_kept", other, 4'h7);

        // Out-of-range addresses
        wrBase = wrCnt;
        access(1'b1, 1'b0, 3'd6, 4'h0, lat, err, dout, other);
        chk("b_rd6_lat", lat, 2);
        chk("b_rd6_err", err, 1);
        chk("b_rd6_do", dout, 0);
        access(1'b1, 1'b1, 3'd7, 4'h5, lat, err, dout, other);
        chk("b_wr7_err", err, 1);
        chk("b_wr7_nowrite", wrCnt - wrBase, 0);
        chk("a_do_kept", other, 4'hA);

        // Reset during an A write access, then a request raised mid-clear
        @(negedge CLK);
        A_WR = 1'b1; A_ADR = 3'd4; A_DI = 4'hC; A_REQ = 1'b1;
        @(negedge CLK);
        chk("acc_men", M_EN, 1);
        RST = 1'b1;
        @(negedge CLK);
        A_REQ = 1'b0;
        chk("abort_gnt", A_GNT, 0);
        chk("abort_busy", BUSY, 1);
        @(negedge CLK);
        wrBase = wrCnt;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        access(1'b0, 1'b0, 3'd4, 4'h0, lat, err, dout, other);
        chk("pend_lat", lat, 6);
        chk("pend_do", dout, 0);
        chk("reclr_writes", wrCnt - wrBase, 6);

        // Both ports requesting continuously from reset
        @(negedge CLK);
        RST = 1'b1;
        A_WR = 1'b1; A_ADR = 3'd2; A_DI = 4'h3; A_REQ = 1'b1;
        B_WR = 1'b0; B_ADR = 3'd2; B_REQ = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        runBoth(17, 1'b1);
        chk("rr_count", gT.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < gT.size()) begin
                chk("rr_time", gT[k], expT[k]);
                chk("rr_port", gP[k], expP[k]);
            end
        end
        chk("rr_b_do", B_DO, 4'h3);

        // Pointer was left at B; contention now favours B, then A
        @(negedge CLK);
        A_WR = 1'b1; A_ADR = 3'd5; A_DI = 4'h6; B_WR = 1'b0; B_ADR = 3'd5;
        A_REQ = 1'b1; B_REQ = 1'b1;
        runBoth(5, 1'b0);
        chk("ptr1_count", gT.size(), 2);
        if (gT.size() == 2) begin
            chk("ptr1_first", gP[0], 1);
            chk("ptr1_t0", gT[0], 2);
            chk("ptr1_t1", gT[1], 4);
        end
        chk("ptr1_b_do", B_DO, 4'h0);
        @(negedge CLK);
        A_DI = 4'hE;
        A_REQ = 1'b1; B_REQ = 1'b1;
        runBoth(5, 1'b0);
        chk("ptr2_count", gT.size(), 2);
        if (gT.size() == 2) begin
            chk("ptr2_first", gP[0], 0);
            chk("ptr2_t1", gT[1], 4);
        end
        chk("ptr2_b_do", B_DO, 4'hE);

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/int_memory_arbiter.md
# int_memory_arbiter

Two-port arbiter and sequencer for the 6-entry × 4-bit `int_memory` register file. It shares the memory between two requesters, port A (the core datapath) and port B (the debug/load path), using a request/grant handshake with round-robin priority. It zero-fills all six entries after reset and rejects out-of-range addresses 6 and 7. It sits between both requesters and the single `int_memory` instance and is the only driver of that instance's address, data, enable and write inputs.

## Interface
- `DEPTH`, default 6: number of valid entries. Addresses ≥ DEPTH are invalid.
- `CLEAR_ON_RESET`, default 1: zero-fill the memory after reset. When 0, go straight to IDLE.
- `CLK`  in  1: the block's single clock; all state changes on the rising edge.
- `RST`  in  1: reset, synchronous and active-high.
- `A_REQ`, `B_REQ`  in  1: access request; held high with stable operands until the matching GNT.
- `A_WR`, `B_WR`  in  1: 1 = write, 0 = read.
- `A_ADR`, `B_ADR`  in  3: word address.
- `A_DI`, `B_DI`  in  4: write data.
- `A_GNT`, `B_GNT`  out  1: one-cycle completion pulse.
- `A_ERR`, `B_ERR`  out  1: pulses with GNT when the address was ≥ DEPTH.
- `A_DO`, `B_DO`  out  4: read data, held until that port's next read completes.
- `M_ADR`  out  3: to memory ADR2..0.
- `M_DI`  out  4: to memory DI3..0.
- `M_EN`  out  1: to memory EN.
- `M_WR`  out  1: to memory WR.
- `M_DO`  in  4: from memory DO3..0.
- `BUSY`  out  1: high while in reset or zero-filling.

## Operation
- FSM states: CLEAR, IDLE, ACCESS, DONE.
- RST=1 forces CLEAR with the clear counter at 0, the priority pointer set to "A first", and all outputs at their reset values.
- Reset values: M_EN=0, M_WR=0, M_ADR=0, M_DI=0, both GNT=0, both ERR=0, both DO=0, BUSY=1.
- CLEAR: drive M_EN=1, M_WR=1, M_DI=0, M_ADR=counter. The counter steps 0..DEPTH-1, one word per cycle. After the last word, go to IDLE with M_EN=0 and BUSY=0. Requests raised during CLEAR stay pending.
- IDLE and DONE: sample the requests.
  - A port whose GNT is high in the current cycle is not eligible.
  - With one eligible requester, it wins.
  - With two, the pointer picks the winner, and the pointer then flips to the loser.
  - The winner's operands are registered onto M_ADR/M_DI/M_WR. M_EN=1 only if the address is < DEPTH. Go to ACCESS.
- ACCESS: no sampling.
  - At the ending edge, a write is committed by the memory.
  - A valid read captures M_DO into the winner's DO.
  - An invalid read loads 0 into the winner's DO.
  - An invalid write is discarded.
  - The winner's GNT (plus ERR if invalid) is registered high, and M_EN drops to 0. Go to DONE.
- DONE behaves like IDLE. GNT and ERR are cleared at the next edge.
- The other port's DO is never touched.

## Timing
- All outputs are registered, so memory inputs change only just after a rising edge. This keeps the memory's EN&CLK gated clock glitch-free.
- Request sampled high in cycle n → M_EN high in cycle n+1 → GNT (and DO for a read) valid in cycle n+2.
- The requester drops or replaces REQ at the edge ending n+2. A new request from the same port is first sampled in cycle n+3, so one port alone gets a grant every 3 cycles.
- While A is in ACCESS, a pending B is sampled in A's DONE cycle. Alternating ports therefore sustain one access every 2 cycles.
- Clear sequence: call the first edge with RST=0 E1.
  - From E1: M_ADR=0, M_EN=M_WR=1.
  - Word k is written at edge E(k+2).
  - At E(DEPTH+1) (E7 for DEPTH=6): M_EN=0 and BUSY=0.
  - The first request sample is the cycle after E7.
- RST high mid-access: the access is abandoned with no GNT. Write completion is undefined, because the entry is cleared anyway. The clear sequence restarts.
- Simultaneous GNT for A and B is impossible.

## Structure
- Package `int_memory_pkg` holds:
  - `MEM_DEPTH`=6, `MEM_ADR_W`=3, `MEM_DAT_W`=4;
  - the state enum CLEAR/IDLE/ACCESS/DONE.
- One sub-module, `int_memory_rr2`: a combinational 2-way round-robin picker. Inputs: two eligible requests and the pointer. Outputs: the winner and the next pointer.
- The FSM, operand registers and DO registers live in the top level.

## Test plan
1. Reset: RST high for 2 cycles, then low → M_WR/M_EN pulses write 0 to addresses 0..5 in order, and BUSY falls at E7. A read of each address afterwards returns 0.
2. A writes 0xA to address 3 with REQ in cycle n → A_GNT in cycle n+2. A then reads address 3 → A_DO=0xA alongside A_GNT, and B_DO is unchanged.
3. A and B both hold REQ continuously, right after reset → grants go A, B, A, B, one every 2 cycles. No cycle has both GNTs high.
4. B reads address 6 → M_EN stays 0, B_GNT=B_ERR=1 in cycle n+2, B_DO=0. B writes 0x5 to address 7 → ERR is set and no memory write occurs.
5. A_REQ raised during CLEAR → held pending and granted with its first sample after BUSY falls.
6. RST asserted in the ACCESS cycle of an A write → A_GNT never pulses, and the full clear sequence is re-observed.
